readout_rx_iq_window_integrator: RTL
====================================

Name: readout_rx_iq_window_integrator

Overview:
Upstream feeder of the readout RX state-decision (bin-count) stage. It takes the demodulated signed I/Q sample stream, boxcar-averages it over windows of 2^window_shift samples, and emits one averaged I/Q point per window. It also frames each measurement with single-cycle start_count/finish_count pulses, so the decision stage bins exactly num_windows points per shot.

Parameters:
DATA_WIDTH, 16, width of the signed two's-complement I/Q sample in and out
MAX_WINDOW_SHIFT, 7, largest allowed log2 window length
ACC_WIDTH, DATA_WIDTH+MAX_WINDOW_SHIFT, accumulator width (no overflow possible)
NUM_WINDOW_WIDTH, 8, width of the per-shot window count
CFG_ADDR_WIDTH, 1, config address width
CFG_DATA_WIDTH, 16, config data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_wr_en  in  1  config write strobe
cfg_wr_addr  in  CFG_ADDR_WIDTH  0 = window_shift, 1 = num_windows
cfg_wr_data  in  CFG_DATA_WIDTH  config value, LSB-aligned
start_meas  in  1  single-cycle request to begin one measurement shot
abort_in  in  1  cancel the shot in progress
valid_in  in  1  demodulated sample valid
i_in  in  DATA_WIDTH  signed I sample
q_in  in  DATA_WIDTH  signed Q sample
valid_out  out  1  averaged point valid (one cycle per window)
i_out  out  DATA_WIDTH  signed averaged I
q_out  out  DATA_WIDTH  signed averaged Q
start_count_out  out  1  one-cycle shot-start pulse to the decision stage
finish_count_out  out  1  one-cycle shot-end pulse to the decision stage
busy_out  out  1  high while a shot is in progress

Behaviour:
- Reset: state IDLE. All outputs 0. Accumulators and counters 0. window_shift resets to 0, num_windows resets to 1.
- Config registers:
  - Written only in IDLE; writes while busy_out=1 are ignored.
  - window_shift takes cfg_wr_data[2:0] and is clamped to MAX_WINDOW_SHIFT.
  - num_windows takes cfg_wr_data[NUM_WINDOW_WIDTH-1:0].
  - A config write in the same cycle as start_meas takes effect for that shot.
- Shadow copy: config values are latched into shadow registers on shot start and used for the whole shot.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start_meas=1 → RUN. Sample count, window count and accumulators are cleared. start_count_out=1 in the next cycle only. busy_out=1 from the next cycle.
  - If shadow num_windows=0 → go to FINISH instead of RUN; start_count_out still pulses.
  - valid_in is ignored in IDLE, including in the start_meas cycle.
- RUN:
  - Each valid_in adds the sign-extended i_in/q_in to acc_i/acc_q and increments the sample count (width MAX_WINDOW_SHIFT+1).
  - Last sample of a window (valid_in=1 and sample count = 2^shift − 1): in the next cycle valid_out=1, i_out=(acc_i+i_in)>>>shift, and likewise q_out. This is an arithmetic shift, i.e. floor.
  - In that same edge: accumulators and sample count clear to 0 and the window count increments. Back-to-back windows have no bubble.
  - The result always fits DATA_WIDTH, so no saturation is needed.
  - If shift=0, every valid sample is passed through with 1-cycle latency.
  - When the completed window is number num_windows → FINISH.
  - Gaps in valid_in stall the accumulation; there is no timeout.
  - start_meas in RUN is ignored.
- FINISH (one cycle):
  - finish_count_out=1 in the cycle after the final valid_out.
  - For num_windows=0, finish_count_out=1 in the cycle after start_count_out.
  - Next state IDLE. busy_out drops in the same cycle finish_count_out is high.
- Outputs registered:
  - i_out/q_out hold their last value when valid_out=0.
  - valid_out, start_count_out and finish_count_out are never high in the same cycle.
- abort_in (RUN or FINISH):
  - Next cycle → IDLE and busy_out=0.
  - No valid_out or finish_count_out is generated for the partial window.
  - Accumulators and counters clear.
  - abort_in wins over a simultaneous window completion.
- rst mid-shot: returns to the reset state in the next cycle and no pulses are emitted.

Test Plan:
- shift=2, num_windows=3, start_meas at cycle 0. I samples 4,8,−4,0 | 1,1,1,1 | −3,−3,−3,−2, all Q=0, contiguous from cycle 1. Required: start_count_out @1; valid_out @5, 9, 13 with i_out 2, 1, −3 (floor of −11/4); finish_count_out @14; busy_out low @14.
- shift=0, num_windows=2, samples (100,−5),(−32768,32767): two valid_out, each 1 cycle after its input, with identical values; then finish_count_out.
- shift=7 with all I=32767, then all I=−32768: i_out 32767 and −32768 exactly (no overflow).
- num_windows=0: start_count_out then finish_count_out on consecutive cycles, no valid_out; input samples are ignored.
- abort_in mid-window, then a new shot with shift=1, num_windows=1, I=6,2: no valid_out or finish_count_out for the aborted shot; new shot outputs i_out=4.
- Config write while busy (window_shift=5) then a later shot: the in-flight shot keeps its old shift, and the write is discarded. Also start_meas while busy is ignored, with no second start_count_out.

Source files
------------

// File: rtl/readout_rx_iq_window_integrator.sv
// Boxcar I/Q averager in front of the readout state-decision stage: averages
// 2^shift samples per window and frames each shot with start/finish pulses.
module readout_rx_iq_window_integrator #(
    parameter int DATA_WIDTH       = 16,
    parameter int MAX_WINDOW_SHIFT = 7,
    parameter int ACC_WIDTH        = DATA_WIDTH + MAX_WINDOW_SHIFT,
    parameter int NUM_WINDOW_WIDTH = 8,
    parameter int CFG_ADDR_WIDTH   = 1,
    parameter int CFG_DATA_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_wr_en,
    input  logic [CFG_ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic [CFG_DATA_WIDTH-1:0] cfg_wr_data,
    input  logic                      start_meas,
    input  logic                      abort_in,
    input  logic                      valid_in,
    input  logic [DATA_WIDTH-1:0]     i_in,
    input  logic [DATA_WIDTH-1:0]     q_in,
    output logic                      valid_out,
    output logic [DATA_WIDTH-1:0]     i_out,
    output logic [DATA_WIDTH-1:0]     q_out,
    output logic                      start_count_out,
    output logic                      finish_count_out,
    output logic                      busy_out
);

    // state  | meaning
    // IDLE   | no shot; config writable; waiting for start_meas
    // RUN    | accumulating windows of the current shot
    // FINISH | one-cycle tail that emits finish_count_out
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int SHIFT_W = $clog2(MAX_WINDOW_SHIFT + 1);
    localparam int CNT_W   = MAX_WINDOW_SHIFT + 1;

    state_t                       state_q;
    logic [SHIFT_W-1:0]           shift_cfg_q;
    logic [NUM_WINDOW_WIDTH-1:0]  num_cfg_q;
    logic [SHIFT_W-1:0]           sh_shift_q;
    logic [NUM_WINDOW_WIDTH-1:0]  sh_num_q;
    logic signed [ACC_WIDTH-1:0]  acc_i_q;
    logic signed [ACC_WIDTH-1:0]  acc_q_q;
    logic [CNT_W-1:0]             samp_cnt_q;
    logic [NUM_WINDOW_WIDTH-1:0]  win_cnt_q;
    logic                         valid_q;
    logic                         start_q;
    logic                         finish_q;
    logic                         busy_q;
    logic [DATA_WIDTH-1:0]        i_out_q;
    logic [DATA_WIDTH-1:0]        q_out_q;

    logic [2:0]                   wr_shift_raw;
    logic [SHIFT_W-1:0]           wr_shift;
    logic [NUM_WINDOW_WIDTH-1:0]  wr_num;
    logic                         wr_shift_sel;
    logic                         wr_num_sel;
    logic [SHIFT_W-1:0]           eff_shift;
    logic [NUM_WINDOW_WIDTH-1:0]  eff_num;
    logic signed [ACC_WIDTH-1:0]  ext_i;
    logic signed [ACC_WIDTH-1:0]  ext_q;
    logic signed [ACC_WIDTH-1:0]  sum_i;
    logic signed [ACC_WIDTH-1:0]  sum_q;
    logic [CNT_W-1:0]             win_last_cnt;
    logic                         window_done;
    logic [NUM_WINDOW_WIDTH-1:0]  win_cnt_inc;
    logic                         unused_cfg_bits;

    assign wr_shift_raw = cfg_wr_data[2:0];
    assign wr_num       = cfg_wr_data[NUM_WINDOW_WIDTH-1:0];
    assign wr_shift_sel = cfg_wr_en && (cfg_wr_addr == CFG_ADDR_WIDTH'(0));
    assign wr_num_sel   = cfg_wr_en && (cfg_wr_addr == CFG_ADDR_WIDTH'(1));

    always_comb begin
        if (int'(wr_shift_raw) > MAX_WINDOW_SHIFT) begin
            wr_shift = SHIFT_W'(MAX_WINDOW_SHIFT);
        end else begin
            wr_shift = SHIFT_W'(wr_shift_raw);
        end
    end

    // A write landing in the start cycle must already apply to that shot.
    assign eff_shift = wr_shift_sel ? wr_shift : shift_cfg_q;
    assign eff_num   = wr_num_sel   ? wr_num   : num_cfg_q;

    assign ext_i = {{(ACC_WIDTH - DATA_WIDTH){i_in[DATA_WIDTH-1]}}, i_in};
    assign ext_q = {{(ACC_WIDTH - DATA_WIDTH){q_in[DATA_WIDTH-1]}}, q_in};
    assign sum_i = acc_i_q + ext_i;
    assign sum_q = acc_q_q + ext_q;

    assign win_last_cnt = (CNT_W'(1) << sh_shift_q) - CNT_W'(1);
    assign window_done  = valid_in && (samp_cnt_q == win_last_cnt);
    assign win_cnt_inc  = win_cnt_q + NUM_WINDOW_WIDTH'(1);

    assign unused_cfg_bits = ^cfg_wr_data[CFG_DATA_WIDTH-1:NUM_WINDOW_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_cfg_q <= '0;
            num_cfg_q   <= NUM_WINDOW_WIDTH'(1);
            sh_shift_q  <= '0;
            sh_num_q    <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            samp_cnt_q  <= '0;
            win_cnt_q   <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
        end else begin
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            finish_q <= 1'b0;

            if (state_q == ST_IDLE) begin
                if (wr_shift_sel) shift_cfg_q <= wr_shift;
                if (wr_num_sel)   num_cfg_q   <= wr_num;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_meas) begin
                        sh_shift_q <= eff_shift;
                        sh_num_q   <= eff_num;
                        acc_i_q    <= '0;
                        acc_q_q    <= '0;
                        samp_cnt_q <= '0;
                        win_cnt_q  <= '0;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= (eff_num == '0) ? ST_FINISH : ST_RUN;
                    end
                end

                ST_RUN: begin
                    // Abort outranks a window completing in the same cycle.
                    if (abort_in) begin
                        acc_i_q    <= '0;
                        acc_q_q    <= '0;
                        samp_cnt_q <= '0;
                        win_cnt_q  <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (window_done) begin
                        valid_q    <= 1'b1;
                        i_out_q    <= DATA_WIDTH'(sum_i >>> sh_shift_q);
                        q_out_q    <= DATA_WIDTH'(sum_q >>> sh_shift_q);
                        acc_i_q    <= '0;
                        acc_q_q    <= '0;
                        samp_cnt_q <= '0;
                        win_cnt_q  <= win_cnt_inc;
                        if (win_cnt_inc == sh_num_q) begin
                            state_q <= ST_FINISH;
                        end
                    end else if (valid_in) begin
                        acc_i_q    <= sum_i;
                        acc_q_q    <= sum_q;
                        samp_cnt_q <= samp_cnt_q + CNT_W'(1);
                    end
                end

                ST_FINISH: begin
                    acc_i_q    <= '0;
                    acc_q_q    <= '0;
                    samp_cnt_q <= '0;
                    win_cnt_q  <= '0;
                    busy_q     <= 1'b0;
                    finish_q   <= !abort_in;
                    state_q    <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign valid_out        = valid_q;
    assign i_out            = i_out_q;
    assign q_out            = q_out_q;
    assign start_count_out  = start_q;
    assign finish_count_out = finish_q;
    assign busy_out         = busy_q;

endmodule
